// File: rtl/score_display_ctrl.sv
// score_display_ctrl
// Sequencing controller for the six-digit HEX display bank. Two requesters
// (score on HEX3..HEX0, lives on HEX5) are arbitrated round-robin. The binary
// score is converted to BCD by a one-bit-per-cycle double-dabble engine. The
// block holds registered 4-bit digit codes for the downstream seven_segment
// decoders. Code 4'hF blanks a digit.
module score_display_ctrl #(
  parameter int SCORE_W  = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_req,
  input  logic [SCORE_W-1:0] score_val,
  output logic               score_ack,
  input  logic               lives_req,
  input  logic [3:0]         lives_val,
  output logic               lives_ack,
  output logic               busy,
  output logic [3:0]         hex0_code,
  output logic [3:0]         hex1_code,
  output logic [3:0]         hex2_code,
  output logic [3:0]         hex3_code,
  output logic [3:0]         hex4_code,
  output logic [3:0]         hex5_code
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV     = 2'd1,
    COMMIT_S = 2'd2,
    COMMIT_L = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_SCORE = 1'b0,
    GRANT_LIVES = 1'b1
  } grant_e;

  // The shift counter counts down from SCORE_W-1 to 0: one iteration per bit.
  localparam int                CNT_W    = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(SCORE_W - 1);

  localparam logic [3:0]        BLANK    = 4'hF;
  // Reset value of the leading-zero candidates HEX3..HEX1.
  localparam logic [3:0]        LZ_RST   = BLANK_LZ ? BLANK : 4'h0;

  localparam int                SCORE_MAX = 9999;
  localparam logic [3:0]        LIVES_MAX = 4'd9;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  grant_e               last_q,  last_d;
  logic [SCORE_W-1:0]   bin_q,   bin_d;
  logic [15:0]          bcd_q,   bcd_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [3:0]           lives_q, lives_d;
  logic [3:0]           hex0_q,  hex0_d;
  logic [3:0]           hex1_q,  hex1_d;
  logic [3:0]           hex2_q,  hex2_d;
  logic [3:0]           hex3_q,  hex3_d;
  logic [3:0]           hex5_q,  hex5_d;

  // ---------------------------------------------------------------------------
  // Helper combinational signals
  // ---------------------------------------------------------------------------
  logic [31:0]          score_ext;
  logic [SCORE_W-1:0]   score_sat;
  logic [3:0]           lives_sat;
  logic                 grant_score;
  logic                 grant_lives;
  logic [15:0]          bcd_adj;
  logic [SCORE_W+15:0]  dd_shifted;
  logic                 blank3;
  logic                 blank2;
  logic                 blank1;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // Input saturation and round-robin arbitration, both used only on a grant.
  always_comb begin
    score_ext   = 32'(score_val);
    score_sat   = (score_ext > 32'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_val;
    lives_sat   = (lives_val > LIVES_MAX) ? LIVES_MAX : lives_val;
    // On a tie the requester that was not served last wins.
    grant_score = score_req && (!lives_req || (last_q == GRANT_LIVES));
    grant_lives = lives_req && !grant_score;
  end

  // One double-dabble iteration: adjust, then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj    = dd_adjust(bcd_q);
    dd_shifted = {bcd_adj, bin_q} << 1;
  end

  // Leading-zero blanking chain: a digit blanks only if every digit above it
  // blanked and it is itself zero. HEX0 always shows.
  always_comb begin
    blank3 = BLANK_LZ && (bcd_q[15:12] == 4'd0);
    blank2 = blank3   && (bcd_q[11:8]  == 4'd0);
    blank1 = blank2   && (bcd_q[7:4]   == 4'd0);
  end

  // ---------------------------------------------------------------------------
  // Next-state, datapath and output logic
  // ---------------------------------------------------------------------------
  // FSM next state, datapath updates and state-decoded outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; an unassigned path would infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    hex0_d    = hex0_q;
    hex1_d    = hex1_q;
    hex2_d    = hex2_q;
    hex3_d    = hex3_q;
    hex5_d    = hex5_q;
    score_ack = 1'b0;
    lives_ack = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (grant_score) begin
          bin_d   = score_sat;
          bcd_d   = '0;
          cnt_d   = CNT_INIT;
          last_d  = GRANT_SCORE;
          state_d = CONV;
        end else if (grant_lives) begin
          lives_d = lives_sat;
          last_d  = GRANT_LIVES;
          state_d = COMMIT_L;
        end
      end

      CONV: begin
        bcd_d = dd_shifted[SCORE_W +: 16];
        bin_d = dd_shifted[SCORE_W-1:0];
        if (cnt_q == '0) begin
          state_d = COMMIT_S;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      COMMIT_S: begin
        score_ack = 1'b1;
        hex0_d    = bcd_q[3:0];
        hex1_d    = blank1 ? BLANK : bcd_q[7:4];
        hex2_d    = blank2 ? BLANK : bcd_q[11:8];
        hex3_d    = blank3 ? BLANK : bcd_q[15:12];
        state_d   = IDLE;
      end

      COMMIT_L: begin
        lives_ack = 1'b1;
        hex5_d    = lives_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Control state and displayed digits, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_LIVES;
      lives_q <= 4'd0;
      hex0_q  <= 4'd0;
      hex1_q  <= LZ_RST;
      hex2_q  <= LZ_RST;
      hex3_q  <= LZ_RST;
      hex5_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      lives_q <= lives_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
      hex3_q  <= hex3_d;
      hex5_q  <= hex5_d;
    end
  end

  // Conversion datapath.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always loaded on a score grant before
    // they are used, so a reset would only add fan-out on rst.
    bin_q <= bin_d;
    bcd_q <= bcd_d;
    cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign hex0_code = hex0_q;
  assign hex1_code = hex1_q;
  assign hex2_code = hex2_q;
  assign hex3_code = hex3_q;
  assign hex4_code = BLANK;
  assign hex5_code = hex5_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl (SCORE_W=14, BLANK_LZ=1).
// Table-driven single updates go through a scoreboard queue. Hand-written
// sequences cover arbitration ties, reset during conversion and a held
// request.
module tb_score_display_ctrl;

  typedef struct packed {
    logic [3:0] h5, h4, h3, h2, h1, h0;
  } disp_t;

  typedef struct {
    bit         is_lives;
    int         val;
    logic [3:0] e3, e2, e1, e0, e5;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        score_req, lives_req;
  logic [13:0] score_val;
  logic [3:0]  lives_val;
  logic        score_ack, lives_ack, busy;
  logic [3:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int    n_pass  = 0;
  int    n_total = 0;
  bit    both_acks_seen = 1'b0;
  disp_t cur;
  disp_t rst_disp;
  disp_t sb_q[$];
  vec_t  vecs[14];

  score_display_ctrl #(.SCORE_W(14), .BLANK_LZ(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .score_req (score_req),
    .score_val (score_val),
    .score_ack (score_ack),
    .lives_req (lives_req),
    .lives_val (lives_val),
    .lives_ack (lives_ack),
    .busy      (busy),
    .hex0_code (hex0),
    .hex1_code (hex1),
    .hex2_code (hex2),
    .hex3_code (hex3),
    .hex4_code (hex4),
    .hex5_code (hex5)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (score_ack && lives_ack) both_acks_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic disp_t dut_disp();
    disp_t d;
    d = {hex5, hex4, hex3, hex2, hex1, hex0};
    return d;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    score_req = 1'b0;
    lives_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur = rst_disp;
  endtask

  // Single score update: ack 15 cycles after grant, digits one cycle later.
  task automatic run_score(input int v, input logic [3:0] e3, e2, e1, e0, input string tag);
    disp_t exp;
    int    n, nbusy;
    bit    got;
    exp = cur;
    exp.h3 = e3; exp.h2 = e2; exp.h1 = e1; exp.h0 = e0;
    cur = exp;
    sb_q.push_back(exp);
    @(negedge clk);
    score_val = 14'(v);
    score_req = 1'b1;
    n = 0; nbusy = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) score_val = 14'($urandom);  // value must not matter after grant
      if (busy) nbusy++;
      if (score_ack) got = 1'b1;
    end
    score_req = 1'b0;
    check({tag, " score_ack latency"}, n, 15);
    check({tag, " busy cycles"}, nbusy, 15);
    @(negedge clk);
    exp = sb_q.pop_front();
    check({tag, " display"}, dut_disp(), exp);
    check({tag, " idle after"}, busy, 1'b0);
  endtask

  // Single lives update: ack in the cycle after grant, hex5 one cycle later.
  task automatic run_lives(input int v, input logic [3:0] e5, input string tag);
    disp_t exp;
    int    n, nbusy;
    bit    got;
    exp = cur;
    exp.h5 = e5;
    cur = exp;
    sb_q.push_back(exp);
    @(negedge clk);
    lives_val = 4'(v);
    lives_req = 1'b1;
    n = 0; nbusy = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) lives_val = 4'($urandom);
      if (busy) nbusy++;
      if (lives_ack) got = 1'b1;
    end
    lives_req = 1'b0;
    check({tag, " lives_ack latency"}, n, 1);
    check({tag, " busy cycles"}, nbusy, 1);
    @(negedge clk);
    exp = sb_q.pop_front();
    check({tag, " display"}, dut_disp(), exp);
  endtask

  // Raise both requests together; record the cycle of each ack.
  task automatic collide(input int sv, input int lv, output int s_at, output int l_at);
    int n;
    @(negedge clk);
    score_val = 14'(sv);
    lives_val = 4'(lv);
    score_req = 1'b1;
    lives_req = 1'b1;
    n = 0; s_at = -1; l_at = -1;
    while ((s_at < 0 || l_at < 0) && n < 60) begin
      @(negedge clk);
      n++;
      if (score_ack) begin s_at = n; score_req = 1'b0; end
      if (lives_ack) begin l_at = n; lives_req = 1'b0; end
    end
    score_req = 1'b0;
    lives_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int    s_at, l_at, n, run, max_run;
    bit    seen;
    disp_t exp;

    rst_disp  = '{h5: 4'h0, h4: 4'hF, h3: 4'hF, h2: 4'hF, h1: 4'hF, h0: 4'h0};
    score_val = '0;
    lives_val = '0;

    //            lives  val    e3    e2    e1    e0    e5
    vecs[0]  = '{1'b0,  1234, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
    vecs[1]  = '{1'b0,  7,    4'hF, 4'hF, 4'hF, 4'h7, 4'h0};
    vecs[2]  = '{1'b0,  0,    4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
    vecs[3]  = '{1'b0,  16383,4'h9, 4'h9, 4'h9, 4'h9, 4'h0};
    vecs[4]  = '{1'b1,  12,   4'h0, 4'h0, 4'h0, 4'h0, 4'h9};
    vecs[5]  = '{1'b1,  3,    4'h0, 4'h0, 4'h0, 4'h0, 4'h3};
    vecs[6]  = '{1'b0,  1000, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{1'b0,  10,   4'hF, 4'hF, 4'h1, 4'h0, 4'h0};
    vecs[8]  = '{1'b0,  205,  4'hF, 4'h2, 4'h0, 4'h5, 4'h0};
    vecs[9]  = '{1'b0,  10000,4'h9, 4'h9, 4'h9, 4'h9, 4'h0};
    vecs[10] = '{1'b0,  9998, 4'h9, 4'h9, 4'h9, 4'h8, 4'h0};
    vecs[11] = '{1'b1,  0,    4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[12] = '{1'b1,  10,   4'h0, 4'h0, 4'h0, 4'h0, 4'h9};
    vecs[13] = '{1'b1,  9,    4'h0, 4'h0, 4'h0, 4'h0, 4'h9};

    // Reset state
    do_reset();
    check("reset display", dut_disp(), rst_disp);
    check("reset busy", busy, 1'b0);
    check("reset acks", {score_ack, lives_ack}, 2'b00);

    // Table-driven single updates
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_lives)
        run_lives(vecs[i].val, vecs[i].e5, $sformatf("vec%0d", i));
      else
        run_score(vecs[i].val, vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0,
                  $sformatf("vec%0d", i));
    end

    // Collision after reset: score wins the first tie, lives follows
    // after COMMIT_S, a dead IDLE cycle and COMMIT_L.
    do_reset();
    collide(321, 4, s_at, l_at);
    check("tie1 score_ack cycle", s_at, 15);
    check("tie1 lives_ack cycle", l_at, 17);
    exp = '{h5: 4'h4, h4: 4'hF, h3: 4'hF, h2: 4'h3, h1: 4'h2, h0: 4'h1};
    check("tie1 display", dut_disp(), exp);
    cur = exp;

    // A lone score service makes score the last grant, so the next tie
    // goes to lives.
    run_score(42, 4'hF, 4'hF, 4'h4, 4'h2, "solo");
    collide(88, 6, s_at, l_at);
    check("tie2 lives_ack cycle", l_at, 1);
    check("tie2 score_ack cycle", s_at, 17);
    exp = '{h5: 4'h6, h4: 4'hF, h3: 4'hF, h2: 4'hF, h1: 4'h8, h0: 4'h8};
    check("tie2 display", dut_disp(), exp);

    // Reset during the 5th CONV cycle of 555; request stays held.
    @(negedge clk);
    score_val = 14'd555;
    score_req = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (score_ack) seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (score_ack) seen = 1'b1;
    check("abort no ack", seen, 1'b0);
    check("abort display", dut_disp(), rst_disp);
    check("abort busy", busy, 1'b0);
    rst = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (score_ack) seen = 1'b1;
    end
    score_req = 1'b0;
    check("post-reset score_ack latency", n, 15);
    @(negedge clk);
    exp = '{h5: 4'h0, h4: 4'hF, h3: 4'hF, h2: 4'h5, h1: 4'h5, h0: 4'h5};
    check("post-reset display", dut_disp(), exp);

    // lives_req held continuously: COMMIT_L alternates with a regrant IDLE.
    @(negedge clk);
    lives_val = 4'd5;
    lives_req = 1'b1;
    run = 0; max_run = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("held lives ack c%0d", c), lives_ack, (c % 2) == 1);
      if (busy) run++; else run = 0;
      if (run > max_run) max_run = run;
    end
    lives_req = 1'b0;
    repeat (2) @(negedge clk);
    check("held max busy run", max_run, 1);
    check("held hex5", hex5, 4'h5);
    check("held idle", busy, 1'b0);

    check("acks never together", both_acks_seen, 1'b0);
    check("scoreboard drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
